// File: rtl/shiftreg_pkg.sv
// ============================================================================
// Module      : shiftreg_pkg
// Description : Operation encoding shared by the universal shift register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shiftreg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_t;

  function automatic logic is_shift(input mode_t m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shiftreg_univ_shift_cnt.sv
// ============================================================================
// Module      : shift_cnt
// Description : Saturating shift counter with a one-cycle frame-done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_cnt #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Clear wins over inc so a load on the completing edge suppresses done.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q != C_CNT_MAX) cnt_d = cnt_q + 1'b1;
      done_d = (cnt_q == C_CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: rtl/shiftreg_univ.sv
// ============================================================================
// Module      : shiftreg_univ
// Description : Universal shift register (shift/rotate/load/clear) with frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shiftreg_univ
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  mode_t            mode_w;
  logic [WIDTH-1:0] q_q;
  logic             cnt_clear_w;
  logic             cnt_inc_w;

  assign mode_w      = mode_t'(mode);
  assign cnt_clear_w = en && ((mode_w == MODE_LOAD) || (mode_w == MODE_CLEAR));
  assign cnt_inc_w   = en && is_shift(mode_w);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en) begin
      case (mode_w)
        MODE_SHL:   q_q <= {q_q[WIDTH-2:0], sin_l};
        MODE_SHR:   q_q <= {sin_r, q_q[WIDTH-1:1]};
        MODE_ROL:   q_q <= {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROR:   q_q <= {q_q[0], q_q[WIDTH-1:1]};
        MODE_LOAD:  q_q <= d;
        MODE_CLEAR: q_q <= '0;
        default:    q_q <= q_q;
      endcase
    end
  end

  shift_cnt #(
    .WIDTH (WIDTH)
  ) u_shift_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear_w),
    .inc   (cnt_inc_w),
    .cnt   (cnt),
    .done  (done)
  );

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];

endmodule

`default_nettype wire

// File: tb/tb_shiftreg_univ.sv
// ============================================================================
// Module      : tb_shiftreg_univ
// Description : Directed self-checking bench for shiftreg_univ at WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shiftreg_univ;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] C_HOLD  = 3'b000;
  localparam logic [2:0] C_SHL   = 3'b001;
  localparam logic [2:0] C_SHR   = 3'b010;
  localparam logic [2:0] C_ROL   = 3'b011;
  localparam logic [2:0] C_ROR   = 3'b100;
  localparam logic [2:0] C_LOAD  = 3'b101;
  localparam logic [2:0] C_CLEAR = 3'b110;
  localparam logic [2:0] C_RSVD  = 3'b111;

  logic             clk = 1'b0;
  logic             rst_n, en, sin_l, sin_r;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             sout_l, sout_r, done;
  logic [CNT_W-1:0] cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  shiftreg_univ #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .cnt    (cnt),
    .done   (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply one set of inputs across a rising edge; outputs sampled 1 time unit later.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [WIDTH-1:0] dv, input logic sl, input logic sr);
    rst_n = r; en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [WIDTH-1:0] eq,
                             input logic [CNT_W-1:0] ec, input logic ed);
    check({tag, ".q"},    q,    eq);
    check({tag, ".cnt"},  cnt,  ec);
    check({tag, ".done"}, done, ed);
  endtask

  logic [WIDTH-1:0] frame_q [8]   = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF};
  logic             frame_sl [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [WIDTH-1:0] sat_q [8]     = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = C_HOLD; d = '0; sin_l = 1'b0; sin_r = 1'b0;
    #1;
    step(1'b0, 1'b0, C_HOLD, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, C_HOLD, 8'h00, 1'b0, 1'b0);

    // Reset beats en=1 / LOAD
    step(1'b0, 1'b1, C_LOAD, 8'hFF, 1'b0, 1'b0);
    check_state("reset_prio", 8'h00, 4'd0, 1'b0);

    // Frame: LOAD A5, 8 x SHL with sin_l=1
    step(1'b1, 1'b1, C_LOAD, 8'hA5, 1'b0, 1'b0);
    check_state("frame_load", 8'hA5, 4'd0, 1'b0);
    check("frame_sout_r", sout_r, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("frame_sout_l%0d", i), sout_l, frame_sl[i]);
      step(1'b1, 1'b1, C_SHL, 8'h00, 1'b1, 1'b0);
      check_state($sformatf("frame_shl%0d", i), frame_q[i], CNT_W'(i + 1), (i == 7));
    end
    step(1'b1, 1'b1, C_HOLD, 8'h00, 1'b0, 1'b0);
    check_state("frame_after", 8'hFF, 4'd8, 1'b0);

    // Rotate
    step(1'b1, 1'b1, C_LOAD, 8'h81, 1'b0, 1'b0);
    step(1'b1, 1'b1, C_ROR,  8'h00, 1'b0, 1'b0);
    check_state("ror", 8'hC0, 4'd1, 1'b0);
    check("ror_sout", {sout_l, sout_r}, 2'b10);
    step(1'b1, 1'b1, C_ROL,  8'h00, 1'b0, 1'b0);
    check_state("rol", 8'h81, 4'd2, 1'b0);

    // Saturation via SHR with sin_r=0
    step(1'b1, 1'b1, C_LOAD, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, C_SHR, 8'h00, 1'b0, 1'b0);
      check_state($sformatf("sat_shr%0d", i), sat_q[i], CNT_W'(i + 1), (i == 7));
    end
    step(1'b1, 1'b1, C_SHR, 8'h00, 1'b1, 1'b0);
    check_state("sat_shr8", 8'h00, 4'd8, 1'b0);
    step(1'b1, 1'b1, C_SHR, 8'h00, 1'b0, 1'b1);
    check_state("sat_shr9_sinr", 8'h80, 4'd8, 1'b0);

    // Hold: en=0 and reserved mode
    step(1'b1, 1'b1, C_LOAD, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, C_SHL, 8'hFF, 1'b1, 1'b1);
      check_state($sformatf("hold_en0_%0d", i), 8'h3C, 4'd0, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, C_RSVD, 8'hFF, 1'b1, 1'b1);
      check_state($sformatf("hold_rsvd_%0d", i), 8'h3C, 4'd0, 1'b0);
    end

    // Abort: reset mid-frame
    step(1'b1, 1'b1, C_LOAD, 8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, C_SHL, 8'h00, 1'b0, 1'b0);
    check_state("abort_pre", 8'h00, 4'd4, 1'b0);
    step(1'b0, 1'b1, C_SHL, 8'h00, 1'b1, 1'b0);
    check_state("abort_rst", 8'h00, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, C_SHL, 8'h00, 1'b1, 1'b0);
      check($sformatf("abort_done%0d", i), done, 1'b0);
    end
    check_state("abort_post", 8'h0F, 4'd4, 1'b0);

    // LOAD / CLEAR on the completing edge
    step(1'b1, 1'b1, C_LOAD, 8'h12, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, C_ROL, 8'h00, 1'b0, 1'b0);
    check_state("ld_complete_pre", 8'h09, 4'd7, 1'b0);
    step(1'b1, 1'b1, C_LOAD, 8'h5A, 1'b0, 1'b0);
    check_state("ld_complete", 8'h5A, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, C_ROR, 8'h00, 1'b0, 1'b0);
    check_state("clr_complete_pre", 8'hB4, 4'd7, 1'b0);
    step(1'b1, 1'b1, C_CLEAR, 8'hFF, 1'b0, 1'b0);
    check_state("clr_complete", 8'h00, 4'd0, 1'b0);
    step(1'b1, 1'b1, C_HOLD, 8'h00, 1'b0, 1'b0);
    check_state("clr_after", 8'h00, 4'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shiftreg_univ.md
SHIFTREG_UNIV -- requirements
Module: shiftreg_univ

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 The block SHALL derive localparam CNT_W = $clog2(WIDTH+1), the shift-counter width.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock; the block's only clock.
REQ-004 The block SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 The block SHALL have port en  input  1  operation enable; 0 = hold everything.
REQ-006 The block SHALL have port mode  input  3  operation select (see REQ-013).
REQ-007 The block SHALL have port d  input  WIDTH  parallel load data.
REQ-008 The block SHALL have port sin_l  input  1  serial in, enters bit 0 on shift-left.
REQ-009 The block SHALL have port sin_r  input  1  serial in, enters bit WIDTH-1 on shift-right.
REQ-010 The block SHALL have port q  output  WIDTH  register contents, registered.
REQ-011 The block SHALL have ports sout_l and sout_r  output  1 each: sout_l = q[WIDTH-1], sout_r = q[0]; both are combinational from q.
REQ-012 The block SHALL have ports cnt  output  CNT_W  shifts since last load/clear, and done  output  1  frame-complete pulse.

Function
REQ-013 Mode encoding SHALL be: 000 HOLD, 001 SHL, 010 SHR, 011 ROL, 100 ROR, 101 LOAD, 110 CLEAR, 111 reserved (acts as HOLD).
REQ-014 Update priority at each rising clk edge SHALL be: rst_n=0, then en=0 (hold), then mode.
REQ-015 SHL SHALL set q <= {q[WIDTH-2:0], sin_l}; SHR SHALL set q <= {sin_r, q[WIDTH-1:1]}.
REQ-016 ROL SHALL set q <= {q[WIDTH-2:0], q[WIDTH-1]}; ROR SHALL set q <= {q[0], q[WIDTH-1:1]}.
REQ-017 LOAD SHALL set q <= d and cnt <= 0; CLEAR SHALL set q <= 0 and cnt <= 0.
REQ-018 HOLD, reserved mode and en=0 SHALL leave q and cnt unchanged.
REQ-019 Each SHL/SHR/ROL/ROR SHALL increment cnt by 1, saturating at WIDTH; shifting continues after saturation.
REQ-020 done SHALL be a registered one-cycle pulse, high in the cycle after the edge on which cnt goes from WIDTH-1 to WIDTH.
REQ-021 done SHALL be 0 in all other cycles, including further shifts at saturation and LOAD/CLEAR.
REQ-022 Latency SHALL be one clock: every effect of the inputs sampled at an edge is visible on q/cnt/done immediately after that edge.
REQ-023 A LOAD or CLEAR on the edge that would otherwise complete a frame SHALL produce cnt=0 and no done pulse.

Reset
REQ-024 rst_n=0 at a rising edge SHALL set q=0, cnt=0 and done=0, regardless of en and mode.
REQ-025 Reset asserted mid-frame SHALL abort the frame: cnt restarts from 0 and no done pulse is generated for the aborted frame.
REQ-026 rst_n SHALL have no asynchronous effect; outputs change only on clk edges.

Structure
REQ-027 Package shiftreg_pkg SHALL hold the mode_t enum (3-bit encoding of REQ-013); the module SHALL import it.
REQ-028 The block SHALL contain exactly one sub-module, shift_cnt, parameterised by WIDTH: a saturating counter with clear and inc inputs, cnt output and done-pulse output.
REQ-029 The data path SHALL be a single always_ff with a case on mode; no latches and no derived clocks.

Verification (WIDTH=8)
REQ-030 Reset priority: rst_n=0, en=1, mode=LOAD, d=FF -> after the edge q=00, cnt=0, done=0.
REQ-031 Frame: LOAD A5, then 8 SHL with sin_l=1 -> q=4B, 97, 2F, ... ending at FF; sout_l before each shift = 1,0,1,0,0,1,0,1; cnt=8; done=1 only after the 8th edge.
REQ-032 Rotate: LOAD 81, ROR -> C0, then ROL -> 81; cnt = 1, then 2; done stays 0.
REQ-033 Saturation: LOAD 80, SHR with sin_r=0 -> q=01 and cnt=7 after 7 shifts; 8th -> 00, cnt=8, done pulse; 9th -> cnt=8, done=0.
REQ-034 Hold: after LOAD 3C, en=0 with mode=SHL for 3 cycles, then en=1 with mode=111 for 2 cycles -> q=3C and cnt=0 throughout.
REQ-035 Abort: LOAD F0, 4 SHL, then rst_n=0 -> q=00, cnt=0; 4 further SHL -> cnt=4 and no done pulse.
